// File: rtl/bcd_timer_pkg.sv
// bcd_timer_pkg
// Shared definitions for the BCD countdown timer slice: FSM state
// encoding, BCD digit width/limit and a per-digit clamp helper.
package bcd_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_PAUSE   = 2'd2,
    ST_EXPIRED = 2'd3
  } state_t;

  localparam int               BCD_DIGIT_W = 4;
  localparam logic [BCD_DIGIT_W-1:0] BCD_MAX = 4'd9;

  // Saturate a nibble to a legal BCD digit (10..15 become 9).
  function automatic logic [BCD_DIGIT_W-1:0] bcd_clamp(input logic [BCD_DIGIT_W-1:0] d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/bcd_digit_dec.sv
// bcd_digit_dec
// One BCD digit of a borrow-chain decrementer, purely combinational.
// Ports:
//   D          in  current digit (0..9)
//   BORROW_IN  in  1 = subtract one from this digit
//   Q          out resulting digit
//   BORROW_OUT out 1 = this digit wrapped 0 -> 9 and borrows from the next
module bcd_digit_dec
  import bcd_timer_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] D,
  input  logic                   BORROW_IN,
  output logic [BCD_DIGIT_W-1:0] Q,
  output logic                   BORROW_OUT
);

  always_comb begin
    BORROW_OUT = BORROW_IN && (D == '0);
    if (!BORROW_IN) begin
      Q = D;
    end else if (D == '0) begin
      Q = BCD_MAX;
    end else begin
      Q = D - BCD_DIGIT_W'(1);
    end
  end

endmodule

// File: rtl/bcd_countdown_timer.sv
// bcd_countdown_timer
// Countdown timer that counts natively in BCD over DIGITS digits. A
// prescaler (advanced only while CE=1 in RUN) produces one count step every
// PRESCALE enabled cycles.
// Ports:
//   CLK        in  system clock, rising edge
//   CLR        in  synchronous active-low reset
//   CE         in  prescaler clock enable
//   LOAD       in  1-cycle strobe: load LOAD_VAL (digits clamped to 9), go IDLE
//   LOAD_VAL   in  BCD start value, digit 0 in the LSBs
//   START      in  start/resume strobe
//   STOP       in  pause strobe
//   BCD_Q      out current count
//   RUNNING    out high in RUN
//   EXPIRED    out high in EXPIRED
//   DONE       out 1-cycle pulse when the count reaches 0
//   TICK       out 1-cycle pulse on every count step
//   DBG_STATE  out current FSM state (IDLE=0, RUN=1, PAUSE=2, EXPIRED=3)
// Commands are single-cycle strobes, no handshake; priority is
// CLR > LOAD > STOP > START.
// Build option: define BCD_COUNTDOWN_TIMER_AUTORELOAD_EN to reload the
// stored LOAD value when the count reaches 0 and keep running.
module bcd_countdown_timer
  import bcd_timer_pkg::*;
#(
  parameter int DIGITS        = 4,
  parameter int PRESCALE      = 10000000,
  parameter int PRESCALE_BITS = $clog2(PRESCALE)
) (
  input  logic                CLK,
  input  logic                CLR,
  input  logic                CE,
  input  logic                LOAD,
  input  logic [4*DIGITS-1:0] LOAD_VAL,
  input  logic                START,
  input  logic                STOP,
  output logic [4*DIGITS-1:0] BCD_Q,
  output logic                RUNNING,
  output logic                EXPIRED,
  output logic                DONE,
  output logic                TICK,
  output logic [1:0]          DBG_STATE
);

  // PRESCALE=1 gives a zero-width counter; keep at least one bit.
  localparam int            PW           = (PRESCALE_BITS < 1) ? 1 : PRESCALE_BITS;
  localparam logic [PW-1:0] PRESC_RELOAD = PW'(PRESCALE - 1);

  state_t              state_q;
  logic [PW-1:0]       presc_q;
  logic [4*DIGITS-1:0] dec_q;
  logic [4*DIGITS-1:0] load_clamped;
  logic [DIGITS:0]     borrow;
`ifdef BCD_COUNTDOWN_TIMER_AUTORELOAD_EN
  logic [4*DIGITS-1:0] reload_q;
`endif

  assign DBG_STATE = state_q;
  assign borrow[0] = 1'b1;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_digit_dec u_dec (
      .D          (BCD_Q[i*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .BORROW_IN  (borrow[i]),
      .Q          (dec_q[i*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .BORROW_OUT (borrow[i+1])
    );
    assign load_clamped[i*BCD_DIGIT_W +: BCD_DIGIT_W] =
      bcd_clamp(LOAD_VAL[i*BCD_DIGIT_W +: BCD_DIGIT_W]);
  end

  always_ff @(posedge CLK) begin
    if (!CLR) begin
      state_q  <= ST_IDLE;
      BCD_Q    <= '0;
      presc_q  <= PRESC_RELOAD;
      RUNNING  <= 1'b0;
      EXPIRED  <= 1'b0;
      DONE     <= 1'b0;
      TICK     <= 1'b0;
`ifdef BCD_COUNTDOWN_TIMER_AUTORELOAD_EN
      reload_q <= '0;
`endif
    end else begin
      DONE <= 1'b0;
      TICK <= 1'b0;
      if (LOAD) begin
        state_q  <= ST_IDLE;
        BCD_Q    <= load_clamped;
        presc_q  <= PRESC_RELOAD;
        RUNNING  <= 1'b0;
        EXPIRED  <= 1'b0;
`ifdef BCD_COUNTDOWN_TIMER_AUTORELOAD_EN
        reload_q <= load_clamped;
`endif
      end else if (STOP && state_q == ST_RUN) begin
        // Prescaler holds, so a pause on a step edge defers the step to
        // the first enabled cycle after resume.
        state_q <= ST_PAUSE;
        RUNNING <= 1'b0;
      end else if (START && (state_q == ST_IDLE || state_q == ST_PAUSE)) begin
        if (state_q == ST_IDLE) begin
          presc_q <= PRESC_RELOAD;
        end
        if (BCD_Q == '0) begin
          state_q <= ST_EXPIRED;
          EXPIRED <= 1'b1;
          DONE    <= 1'b1;
        end else begin
          state_q <= ST_RUN;
          RUNNING <= 1'b1;
        end
      end else if (state_q == ST_RUN && CE) begin
        if (presc_q != '0) begin
          presc_q <= presc_q - PW'(1);
        end else if (!borrow[DIGITS]) begin
          // borrow[DIGITS] set means the count is already 0: never wrap.
          presc_q <= PRESC_RELOAD;
          TICK    <= 1'b1;
          if (dec_q == '0) begin
            DONE <= 1'b1;
`ifdef BCD_COUNTDOWN_TIMER_AUTORELOAD_EN
            if (reload_q != '0) begin
              BCD_Q <= reload_q;
            end else begin
              BCD_Q   <= '0;
              state_q <= ST_EXPIRED;
              RUNNING <= 1'b0;
              EXPIRED <= 1'b1;
            end
`else
            BCD_Q   <= '0;
            state_q <= ST_EXPIRED;
            RUNNING <= 1'b0;
            EXPIRED <= 1'b1;
`endif
          end else begin
            BCD_Q <= dec_q;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// tb_bcd_countdown_timer
// Bench for bcd_countdown_timer with DIGITS=2, PRESCALE=4. The reference
// model keeps the count as a plain integer and counts enabled RUN cycles
// since the last step; BCD only appears when comparing against BCD_Q.
module tb_bcd_countdown_timer;

  localparam int DIGITS   = 2;
  localparam int PRESCALE = 4;
  localparam int W        = 4 * DIGITS;
  localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_EXP = 3;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic         CLR, CE, LOAD, START, STOP;
  logic [W-1:0] LOAD_VAL;
  logic [W-1:0] BCD_Q;
  logic         RUNNING, EXPIRED, DONE, TICK;
  logic [1:0]   DBG_STATE;

  bcd_countdown_timer #(.DIGITS(DIGITS), .PRESCALE(PRESCALE)) dut (
    .CLK(CLK), .CLR(CLR), .CE(CE), .LOAD(LOAD), .LOAD_VAL(LOAD_VAL),
    .START(START), .STOP(STOP), .BCD_Q(BCD_Q), .RUNNING(RUNNING),
    .EXPIRED(EXPIRED), .DONE(DONE), .TICK(TICK), .DBG_STATE(DBG_STATE)
  );

  int n_pass  = 0;
  int n_total = 0;
  int cyc_n   = 0;

  // ---------------- reference model ----------------
  int m_val = 0, m_reload = 0, m_state = S_IDLE, m_el = 0;
  bit m_done = 0, m_tick = 0;
`ifdef BCD_COUNTDOWN_TIMER_AUTORELOAD_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r;
    int t;
    r = '0;
    t = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[i*4 +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic int load_value(input logic [W-1:0] lv);
    int v, p;
    v = 0;
    p = 1;
    for (int i = 0; i < DIGITS; i++) begin
      int d;
      d = int'(lv[i*4 +: 4]);
      if (d > 9) d = 9;
      v += d * p;
      p *= 10;
    end
    return v;
  endfunction

  function automatic void model_step(input logic clr, ce, load, input logic [W-1:0] lv,
                                     input logic start, stop);
    m_done = 0;
    m_tick = 0;
    if (!clr) begin
      m_state = S_IDLE; m_val = 0; m_reload = 0; m_el = 0;
    end else if (load) begin
      m_val = load_value(lv); m_reload = m_val; m_state = S_IDLE; m_el = 0;
    end else if (stop && m_state == S_RUN) begin
      m_state = S_PAUSE;
    end else if (start && (m_state == S_IDLE || m_state == S_PAUSE)) begin
      if (m_state == S_IDLE) m_el = 0;
      if (m_val == 0) begin
        m_state = S_EXP; m_done = 1;
      end else begin
        m_state = S_RUN;
      end
    end else if (m_state == S_RUN && ce) begin
      if (m_el == PRESCALE - 1) begin
        m_el = 0;
        m_tick = 1;
        m_val = m_val - 1;
        if (m_val == 0) begin
          m_done = 1;
          if (AUTO && m_reload != 0) m_val = m_reload;
          else m_state = S_EXP;
        end
      end else begin
        m_el = m_el + 1;
      end
    end
  endfunction

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc_n);
  endtask

  // ---------------- driver ----------------
  task automatic cyc(input logic clr, ce, load, input logic [W-1:0] lv, input logic start, stop);
    CLR = clr; CE = ce; LOAD = load; LOAD_VAL = lv; START = start; STOP = stop;
    @(posedge CLK);
    model_step(clr, ce, load, lv, start, stop);
    cyc_n++;
    #1;
    check("bcd_q",   BCD_Q,     to_bcd(m_val));
    check("running", RUNNING,   m_state == S_RUN);
    check("expired", EXPIRED,   m_state == S_EXP);
    check("done",    DONE,      m_done);
    check("tick",    TICK,      m_tick);
    check("state",   DBG_STATE, m_state);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1, 1, 0, '0, 0, 0);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic clr, ce, load;
    logic [W-1:0] lv;
    logic start, stop;
    logic [W-1:0] e_bcd;
    logic e_run, e_exp, e_done, e_tick;
  } vec_t;

  vec_t tbl[12];

  initial begin
    int last_t, dones, ticks, gap0, gap1, n;
    CLR = 0; CE = 0; LOAD = 0; LOAD_VAL = '0; START = 0; STOP = 0;

    //            clr  ce   ld   lv     st   sp   bcd    run  exp  done tick
    tbl[0]  = '{1'b0,1'b1,1'b0,8'h00,1'b0,1'b0, 8'h00,1'b0,1'b0,1'b0,1'b0};
    tbl[1]  = '{1'b1,1'b1,1'b1,8'hF3,1'b0,1'b0, 8'h93,1'b0,1'b0,1'b0,1'b0};
    tbl[2]  = '{1'b1,1'b1,1'b1,8'h00,1'b0,1'b0, 8'h00,1'b0,1'b0,1'b0,1'b0};
    tbl[3]  = '{1'b1,1'b1,1'b0,8'h00,1'b1,1'b0, 8'h00,1'b0,1'b1,1'b1,1'b0};
    tbl[4]  = '{1'b1,1'b1,1'b0,8'h00,1'b0,1'b0, 8'h00,1'b0,1'b1,1'b0,1'b0};
    tbl[5]  = '{1'b1,1'b1,1'b0,8'h00,1'b1,1'b0, 8'h00,1'b0,1'b1,1'b0,1'b0};
    tbl[6]  = '{1'b1,1'b1,1'b1,8'h5A,1'b0,1'b0, 8'h59,1'b0,1'b0,1'b0,1'b0};
    tbl[7]  = '{1'b1,1'b1,1'b0,8'h00,1'b1,1'b0, 8'h59,1'b1,1'b0,1'b0,1'b0};
    tbl[8]  = '{1'b1,1'b1,1'b0,8'h00,1'b0,1'b0, 8'h59,1'b1,1'b0,1'b0,1'b0};
    tbl[9]  = '{1'b1,1'b1,1'b0,8'h00,1'b0,1'b1, 8'h59,1'b0,1'b0,1'b0,1'b0};
    tbl[10] = '{1'b1,1'b1,1'b1,8'h21,1'b1,1'b0, 8'h21,1'b0,1'b0,1'b0,1'b0};
    tbl[11] = '{1'b0,1'b1,1'b1,8'h44,1'b0,1'b0, 8'h00,1'b0,1'b0,1'b0,1'b0};

    for (int i = 0; i < 12; i++) begin
      cyc(tbl[i].clr, tbl[i].ce, tbl[i].load, tbl[i].lv, tbl[i].start, tbl[i].stop);
      check("tbl_bcd",  BCD_Q,   tbl[i].e_bcd);
      check("tbl_run",  RUNNING, tbl[i].e_run);
      check("tbl_exp",  EXPIRED, tbl[i].e_exp);
      check("tbl_done", DONE,    tbl[i].e_done);
      check("tbl_tick", TICK,    tbl[i].e_tick);
    end

    // Full countdown 12 -> 00 with a step every 4 cycles.
    cyc(1, 1, 1, 8'h12, 0, 0);
    cyc(1, 1, 0, '0, 1, 0);
    last_t = cyc_n;
    exp_q = '{8'h11, 8'h10, 8'h09, 8'h08, 8'h07, 8'h06, 8'h05, 8'h04,
              8'h03, 8'h02, 8'h01};
`ifdef BCD_COUNTDOWN_TIMER_AUTORELOAD_EN
    exp_q.push_back(8'h12);
`else
    exp_q.push_back(8'h00);
`endif
    dones = 0;
    for (int k = 0; k < 80 && exp_q.size() > 0; k++) begin
      cyc(1, 1, 0, '0, 0, 0);
      if (DONE) dones++;
      if (TICK) begin
        check("t1_step_val", BCD_Q, exp_q.pop_front());
        check("t1_tick_gap", cyc_n - last_t, PRESCALE);
        last_t = cyc_n;
      end
    end
    check("t1_all_steps", exp_q.size(), 0);
    check("t1_done_count", dones, 1);
`ifndef BCD_COUNTDOWN_TIMER_AUTORELOAD_EN
    ticks = 0;
    for (int k = 0; k < 8; k++) begin
      cyc(1, 1, 0, '0, 0, 0);
      if (TICK || DONE) ticks++;
    end
    check("t1_quiet_after_expiry", ticks, 0);
    check("t1_expired_held", EXPIRED, 1);
`endif

    // Pause for 10 cycles part-way through a period: no drift.
    cyc(1, 1, 1, 8'h05, 0, 0);
    cyc(1, 1, 0, '0, 1, 0);
    idle(2);
    cyc(1, 1, 0, '0, 0, 1);
    idle(10);
    check("t2_pause_hold", BCD_Q, 8'h05);
    cyc(1, 1, 0, '0, 1, 0);
    n = 0;
    for (int k = 0; k < 10; k++) begin
      cyc(1, 1, 0, '0, 0, 0);
      n++;
      if (TICK) break;
    end
    check("t2_cycles_after_resume", n, 2);
    check("t2_bcd_after_step", BCD_Q, 8'h04);

    // CE toggling 1-0-1-0: steps every 4 CE-high cycles.
    cyc(1, 1, 1, 8'h03, 0, 0);
    cyc(1, 1, 0, '0, 1, 0);
    last_t = cyc_n; gap0 = -1; gap1 = -1; ticks = 0;
    for (int k = 0; k < 40 && ticks < 2; k++) begin
      cyc(1, (k % 2) == 0, 0, '0, 0, 0);
      if (TICK) begin
        if (ticks == 0) gap0 = cyc_n - last_t; else gap1 = cyc_n - last_t;
        last_t = cyc_n;
        ticks++;
      end
    end
    check("t3_first_gap", gap0, 7);
    check("t3_tick_gap", gap1, 8);

    // STOP on the step edge: step deferred to first CE cycle after resume.
    cyc(1, 1, 1, 8'h02, 0, 0);
    cyc(1, 1, 0, '0, 1, 0);
    idle(3);
    cyc(1, 1, 0, '0, 0, 1);
    check("t7_stop_wins_tick", TICK, 0);
    check("t7_stop_wins_bcd", BCD_Q, 8'h02);
    idle(5);
    cyc(1, 1, 0, '0, 1, 0);
    cyc(1, 1, 0, '0, 0, 0);
    check("t7_resume_tick", TICK, 1);
    check("t7_resume_bcd", BCD_Q, 8'h01);

    // LOAD on the expiry edge wins: no DONE.
    cyc(1, 1, 1, 8'h01, 0, 0);
    cyc(1, 1, 0, '0, 1, 0);
    idle(3);
    cyc(1, 1, 1, 8'h07, 0, 0);
    check("t8_load_wins_done", DONE, 0);
    check("t8_load_wins_bcd", BCD_Q, 8'h07);

    // Reset mid-run at 07.
    cyc(1, 1, 1, 8'h09, 0, 0);
    cyc(1, 1, 0, '0, 1, 0);
    for (int k = 0; k < 20 && BCD_Q != 8'h07; k++) cyc(1, 1, 0, '0, 0, 0);
    check("t5_reached_07", BCD_Q, 8'h07);
    cyc(0, 1, 0, '0, 0, 0);
    check("t5_rst_bcd", BCD_Q, 8'h00);
    check("t5_rst_flags", {RUNNING, EXPIRED, DONE, TICK}, 4'b0000);
    check("t5_rst_state", DBG_STATE, S_IDLE);

`ifdef BCD_COUNTDOWN_TIMER_AUTORELOAD_EN
    // Auto-reload: 02,01,02,01,... with DONE on each reload.
    cyc(1, 1, 1, 8'h02, 0, 0);
    cyc(1, 1, 0, '0, 1, 0);
    exp_q = '{8'h01, 8'h02, 8'h01, 8'h02};
    for (int k = 0; k < 40 && exp_q.size() > 0; k++) begin
      cyc(1, 1, 0, '0, 0, 0);
      if (TICK) begin
        check("t6_step_val", BCD_Q, exp_q.pop_front());
        check("t6_done_on_reload", DONE, BCD_Q == 8'h02);
        check("t6_never_expired", EXPIRED, 0);
      end
    end
    check("t6_all_steps", exp_q.size(), 0);
`endif

    // Randomized commands against the model.
    for (int k = 0; k < 1500; k++) begin
      logic [W-1:0] lv;
      lv = ($urandom_range(0, 1) == 0) ? W'($urandom_range(0, 255)) : W'($urandom_range(0, 3));
      cyc($urandom_range(0, 39) != 0, $urandom_range(0, 3) != 0,
          $urandom_range(0, 19) == 0, lv,
          $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/bcd_countdown_timer.md
Name: bcd_countdown_timer

Overview:
Parametrised countdown timer core that counts down natively in BCD across DIGITS decimal digits. Time base comes from an internal prescaler gated by CE. Supports load, start, pause and expiry detection. BCD_Q feeds the 7-segment display driver directly, so no binary-to-BCD conversion stage is needed. Next-generation replacement for the fixed 4-digit seconds countdown path in the top level.

Parameters:
DIGITS, 4, number of BCD digits (1..8)
PRESCALE, 10000000, enabled CLK cycles per count step (>=1)
PRESCALE_BITS, $clog2(PRESCALE), prescaler register width (derived, not overridden)

Ports:
CLK  in  1  system clock, rising edge
CLR  in  1  synchronous, active-low reset
CE  in  1  clock enable for the prescaler only
LOAD  in  1  load LOAD_VAL, 1-cycle strobe
LOAD_VAL  in  4*DIGITS  BCD start value, digit 0 = LSBs
START  in  1  start/resume strobe
STOP  in  1  pause strobe
BCD_Q  out  4*DIGITS  current BCD count
RUNNING  out  1  high in RUN state
EXPIRED  out  1  high in EXPIRED state
DONE  out  1  1-cycle pulse when count reaches 0
TICK  out  1  1-cycle pulse on each count step

Behaviour:
- All state is registered on the CLK rising edge. No combinational path from inputs to outputs.
- Reset (CLR=0), checked every edge with highest priority: state=IDLE, BCD_Q=0, stored reload value=0, prescaler=PRESCALE-1, RUNNING=0, EXPIRED=0, DONE=0, TICK=0. Reset mid-count aborts the count immediately.
- Command priority: CLR > LOAD > STOP > START.
- FSM states: IDLE, RUN, PAUSE, EXPIRED.
  - LOAD (any state) -> IDLE. BCD_Q and the reload register both take LOAD_VAL. Prescaler reloads PRESCALE-1. DONE and TICK are low that cycle.
  - LOAD_VAL digits >9 are clamped to 9 per digit.
  - START in IDLE or PAUSE: if BCD_Q==0, go to EXPIRED and pulse DONE. Otherwise go to RUN.
  - START from IDLE reloads the prescaler to PRESCALE-1. START from PAUSE keeps the prescaler value, so a pause causes no drift.
  - START in RUN or EXPIRED is ignored.
  - STOP in RUN -> PAUSE; ignored in any other state.
- In RUN with CE=1, the prescaler decrements.
  - At prescaler==0 it reloads PRESCALE-1 and a step occurs. TICK=1 on the edge where BCD_Q updates.
  - CE=0 freezes the prescaler; commands are still accepted.
- Step arithmetic: BCD decrement with a borrow chain. Each digit 0 becomes 9 and borrows from the next digit; a non-zero digit decrements by 1.
- If the step result is all zero: BCD_Q=0, state=EXPIRED, and DONE=1 on that same edge, so DONE and TICK coincide with BCD_Q turning 0.
- Stepping never wraps below 0.
- First step lands exactly PRESCALE CE-cycles after START from IDLE.
- STOP and a step on the same edge: STOP wins, no step occurs, and the prescaler holds at 0. The step then fires on the first CE cycle after resume.
- LOAD on the same edge as expiry: LOAD wins and DONE stays low.
- EXPIRED is held until LOAD or reset.

Optional Feature:
Macro BCD_COUNTDOWN_TIMER_AUTORELOAD_EN.
- Defined: on the step that reaches 0, BCD_Q takes the reload register value and the FSM stays in RUN.
  - DONE pulses every period; EXPIRED is never set by expiry.
  - If the reload value is 0, behaviour is the same as without the macro.
- Not defined: behaviour is exactly as described in Behaviour, and the reload register may be optimised away.

Decomposition:
- Package bcd_timer_pkg holds:
  - state enum/localparams: IDLE=2'd0, RUN=2'd1, PAUSE=2'd2, EXPIRED=2'd3
  - BCD_DIGIT_W=4 and BCD_MAX=4'd9
  - a BCD clamp function
- Sub-module bcd_digit_dec: one digit, combinational.
  - Inputs: D[3:0] and BORROW_IN.
  - Outputs: Q[3:0] and BORROW_OUT.
  - Instantiated DIGITS times in a generate loop.
- Prescaler and FSM live in the top module.

Test Plan:
1. DIGITS=2, PRESCALE=4: LOAD 0x12, START, CE=1 constantly. Required: BCD_Q 12→11→10→09 with a TICK every 4 cycles; 09 follows 10 via the borrow. Reaches 00 at the 12th step, DONE=1 for exactly 1 cycle, EXPIRED=1, TICK stops.
2. PRESCALE=4: START, wait 2 cycles, STOP for 10 cycles, START. Required: the first step occurs 2 CE-cycles after resume, giving total elapsed RUN cycles of 4. BCD_Q is unchanged during PAUSE.
3. Toggle CE as 1-0-1-0 during RUN. Required: step interval equals 4 CE-high cycles, and TICK spacing doubles.
4. LOAD 0xF3 (invalid digit). Required: BCD_Q=0x93. Also LOAD 0x00 then START: EXPIRED next cycle, DONE 1-cycle pulse, no TICK.
5. CLR=0 mid-RUN at BCD_Q=0x07. Required: next edge BCD_Q=0, IDLE, all flags 0. CLR=0 asserted on the same edge as LOAD is also covered, and reset wins.
6. With AUTORELOAD_EN: LOAD 0x02, START. Required: BCD_Q sequence 02,01,02,01,… with a DONE pulse on each 01→02 transition and EXPIRED held at 0.
